iir_lpf_driver: RTL and testbench

Initiator/consumer end of the float IIR low-pass filter handshake. It accepts raw signed fixed-point ADC samples and converts each one exactly to IEEE-754 single precision with a sequential normalizer. It presents the result to the filter's X input as a single-cycle strobe, collects the filter's Y output with a single-cycle acknowledge, and holds the filtered float for the downstream consumer. It sits between the ADC front-end and the filter in the sensor datapath.

---
 rtl/iir_lpf_driver.sv | 146 ++++++++++++++
 tb/tb_iir_lpf_driver.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_lpf_driver.sv
// Drives the float IIR low-pass filter: converts signed ADC samples to IEEE-754
// single precision, hands them to the filter and holds the filtered result.
module iir_lpf_driver #(
  parameter int ADC_W = 24
) (
  input  logic             i_CLK,
  input  logic             i_RSTN,
  input  logic [ADC_W-1:0] i_ADC_DATA,
  input  logic             i_ADC_DATA_VALID,
  output logic [31:0]      o_LPF_X_DATA,
  output logic             o_LPF_X_DATA_VALID,
  input  logic             i_LPF_X_DATA_READY,
  input  logic [31:0]      i_LPF_Y_DATA,
  input  logic             i_LPF_Y_DATA_VALID,
  output logic             o_LPF_Y_ACK,
  output logic [31:0]      o_FILT_DATA,
  output logic             o_FILT_DATA_VALID,
  input  logic             i_FILT_ACK,
  output logic             o_BUSY,
  output logic             o_OVERRUN,
  input  logic             i_OVERRUN_CLR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_NORM,
    S_SEND,
    S_WAIT_Y,
    S_OUT
  } state_t;

  state_t           state, state_d;
  logic [ADC_W-1:0] sample, sample_d;
  logic             sign, sign_d;
  logic [23:0]      mag, mag_d;
  logic [7:0]       expo, expo_d;
  logic [31:0]      x_data_d, filt_data_d;
  logic             x_valid_d, y_ack_d, filt_valid_d, busy_d, overrun_d;
  logic [23:0]      sample_ext;

  // Sign-extend to 24 bits; negating in 24 bits maps -2^(ADC_W-1) onto its magnitude.
  assign sample_ext = 24'($signed(sample));

  always_comb begin
    state_d      = state;
    sample_d     = sample;
    sign_d       = sign;
    mag_d        = mag;
    expo_d       = expo;
    x_data_d     = o_LPF_X_DATA;
    x_valid_d    = 1'b0;
    y_ack_d      = 1'b0;
    filt_data_d  = o_FILT_DATA;
    filt_valid_d = o_FILT_DATA_VALID;

    case (state)
      S_IDLE: begin
        if (i_ADC_DATA_VALID) begin
          sample_d = i_ADC_DATA;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        sign_d = sample[ADC_W-1];
        mag_d  = sample[ADC_W-1] ? (~sample_ext + 24'd1) : sample_ext;
        expo_d = 8'd150;
        if (mag_d == '0) begin
          x_data_d = '0;
          state_d  = S_SEND;
        end else begin
          state_d  = S_NORM;
        end
      end
      S_NORM: begin
        if (mag[23]) begin
          x_data_d = {sign, expo, mag[22:0]};
          state_d  = S_SEND;
        end else begin
          mag_d  = {mag[22:0], 1'b0};
          expo_d = expo - 8'd1;
        end
      end
      S_SEND: begin
        if (i_LPF_X_DATA_READY) begin
          x_valid_d = 1'b1;
          state_d   = S_WAIT_Y;
        end
      end
      S_WAIT_Y: begin
        if (i_LPF_Y_DATA_VALID) begin
          filt_data_d = i_LPF_Y_DATA;
          y_ack_d     = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        // The consumer's ack only counts once it has been shown valid data.
        if (o_FILT_DATA_VALID && i_FILT_ACK) begin
          filt_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          filt_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_ADC_DATA_VALID && (state != S_IDLE)) overrun_d = 1'b1;
    else if (i_OVERRUN_CLR)                    overrun_d = 1'b0;
    else                                       overrun_d = o_OVERRUN;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state              <= S_IDLE;
      sample             <= '0;
      sign               <= 1'b0;
      mag                <= '0;
      expo               <= '0;
      o_LPF_X_DATA       <= '0;
      o_LPF_X_DATA_VALID <= 1'b0;
      o_LPF_Y_ACK        <= 1'b0;
      o_FILT_DATA        <= '0;
      o_FILT_DATA_VALID  <= 1'b0;
      o_BUSY             <= 1'b0;
      o_OVERRUN          <= 1'b0;
    end else begin
      state              <= state_d;
      sample             <= sample_d;
      sign               <= sign_d;
      mag                <= mag_d;
      expo               <= expo_d;
      o_LPF_X_DATA       <= x_data_d;
      o_LPF_X_DATA_VALID <= x_valid_d;
      o_LPF_Y_ACK        <= y_ack_d;
      o_FILT_DATA        <= filt_data_d;
      o_FILT_DATA_VALID  <= filt_valid_d;
      o_BUSY             <= busy_d;
      o_OVERRUN          <= overrun_d;
    end
  end

endmodule

// File: tb/tb_iir_lpf_driver.sv
// Self-checking bench for iir_lpf_driver with a behavioural filter model and
// expected-value queues for the X and filtered outputs.
module tb_iir_lpf_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [31:0] x_data;
  logic        x_valid;
  logic        x_ready = 1'b1;
  logic [31:0] y_data = '0;
  logic        y_valid = 1'b0;
  logic        y_ack;
  logic [31:0] filt_data;
  logic        filt_valid;
  logic        filt_ack = 1'b0;
  logic        busy;
  logic        ovr;
  logic        ovr_clr = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] xq[$];
  logic [31:0] yq[$];

  iir_lpf_driver #(.ADC_W(24)) dut (
    .i_CLK              (clk),
    .i_RSTN             (rst_n),
    .i_ADC_DATA         (adc_data),
    .i_ADC_DATA_VALID   (adc_valid),
    .o_LPF_X_DATA       (x_data),
    .o_LPF_X_DATA_VALID (x_valid),
    .i_LPF_X_DATA_READY (x_ready),
    .i_LPF_Y_DATA       (y_data),
    .i_LPF_Y_DATA_VALID (y_valid),
    .o_LPF_Y_ACK        (y_ack),
    .o_FILT_DATA        (filt_data),
    .o_FILT_DATA_VALID  (filt_valid),
    .i_FILT_ACK         (filt_ack),
    .o_BUSY             (busy),
    .o_OVERRUN          (ovr),
    .i_OVERRUN_CLR      (ovr_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] mag_of(input logic [23:0] s);
    return s[23] ? (24'd0 - s) : s;
  endfunction

  function automatic int lz_of(input logic [23:0] m);
    int n = 0;
    for (int i = 23; i >= 0; i--) begin
      if (m[i]) break;
      n++;
    end
    return n;
  endfunction

  // Reference conversion: locate the MSB, exponent = 127 + position.
  function automatic logic [31:0] float_ref(input logic [23:0] s);
    logic [23:0] m;
    logic [23:0] sh;
    int p;
    m = mag_of(s);
    if (m == '0) return 32'h0;
    p = 23 - lz_of(m);
    sh = m << (23 - p);
    return {s[23], 8'(127 + p), sh[22:0]};
  endfunction

  // Filter model output: an arbitrary but deterministic mapping of X.
  function automatic logic [31:0] filt_model(input logic [31:0] x);
    return x + 32'h0080_0000;
  endfunction

  task automatic run_txn(input logic [23:0] s, input logic [31:0] fexp,
                         input int rdy_wait, input int y_hold,
                         input bit ovr_wait, input bit ovr_out,
                         input bit clr_with, input bit abort_out);
    int lat, kv, stable_bad, acks;
    logic [31:0] xexp, yexp;
    lat = (mag_of(s) == '0) ? 2 : lz_of(mag_of(s)) + 3;
    xq.push_back(fexp);
    adc_data  = s;
    adc_valid = 1'b1;
    x_ready   = (rdy_wait == 0);
    tick;
    adc_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_after_capture s=%h got=%b exp=1", s, busy);
    end
    kv = -1;
    stable_bad = 0;
    for (int k = 1; k <= lat + rdy_wait + 5; k++) begin
      tick;
      if (x_valid) begin kv = k; break; end
      if (!x_ready && k >= lat - 1 && x_data !== fexp) stable_bad++;
      if (rdy_wait > 0 && k == lat - 1 + rdy_wait) x_ready = 1'b1;
    end
    total++;
    if (kv != lat + rdy_wait) begin
      bad++; $display("FAIL x_valid_cycle s=%h got=%0d exp=%0d", s, kv, lat + rdy_wait);
    end
    if (rdy_wait > 0) begin
      total++;
      if (stable_bad != 0) begin
        bad++; $display("FAIL x_data_stall_stable s=%h unstable_cycles=%0d exp=0", s, stable_bad);
      end
    end
    xexp = xq.pop_front();
    total++;
    if (x_data !== xexp) begin
      bad++; $display("FAIL x_data s=%h got=%h exp=%h", s, x_data, xexp);
    end
    yexp = filt_model(xexp);
    yq.push_back(yexp);
    tick;
    total++;
    if (x_valid !== 1'b0) begin
      bad++; $display("FAIL x_valid_one_cycle s=%h got=%b exp=0", s, x_valid);
    end
    if (ovr_wait) begin
      adc_data  = 24'h123456;
      adc_valid = 1'b1;
      ovr_clr   = clr_with;
      tick;
      adc_valid = 1'b0;
      ovr_clr   = 1'b0;
    end
    y_data  = yexp;
    y_valid = 1'b1;
    acks    = 0;
    for (int j = 1; j <= y_hold + 2; j++) begin
      tick;
      if (y_ack) acks++;
      if (j == y_hold) y_valid = 1'b0;
    end
    total++;
    if (acks != 1) begin
      bad++; $display("FAIL y_ack_count s=%h got=%0d exp=1", s, acks);
    end
    yexp = yq.pop_front();
    total++;
    if ({filt_valid, filt_data} !== {1'b1, yexp}) begin
      bad++; $display("FAIL filt_out s=%h got=%b/%h exp=1/%h", s, filt_valid, filt_data, yexp);
    end
    if (abort_out) begin
      rst_n = 1'b0;
      #1;
      total++;
      if ({x_data, x_valid, y_ack, filt_data, filt_valid, busy, ovr} !== '0) begin
        bad++; $display("FAIL reset_in_out got=%h/%b/%b/%h/%b/%b/%b exp=all0",
                        x_data, x_valid, y_ack, filt_data, filt_valid, busy, ovr);
      end
      tick;
      rst_n = 1'b1;
      tick;
      return;
    end
    repeat (3) tick;
    total++;
    if ({filt_valid, filt_data} !== {1'b1, yexp}) begin
      bad++; $display("FAIL filt_hold s=%h got=%b/%h exp=1/%h", s, filt_valid, filt_data, yexp);
    end
    filt_ack = 1'b1;
    if (ovr_out) begin
      adc_data  = 24'h654321;
      adc_valid = 1'b1;
    end
    tick;
    filt_ack  = 1'b0;
    adc_valid = 1'b0;
    total++;
    if ({filt_valid, busy, filt_data} !== {1'b0, 1'b0, yexp}) begin
      bad++; $display("FAIL filt_release s=%h got=%b/%b/%h exp=0/0/%h", s, filt_valid, busy, filt_data, yexp);
    end
    tick;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_release s=%h busy got=%b exp=0", s, busy);
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({x_data, x_valid, y_ack, filt_data, filt_valid, busy, ovr} !== '0) begin
      bad++; $display("FAIL reset_state got=%h/%b/%b/%h/%b/%b/%b exp=all0",
                      x_data, x_valid, y_ack, filt_data, filt_valid, busy, ovr);
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_convert;
    logic [23:0] s_tab[5] = '{24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000, 24'h000000};
    logic [31:0] f_tab[5] = '{32'h3F800000, 32'hBF800000, 32'h4AFFFFFE, 32'hCB000000, 32'h00000000};
    logic [23:0] r;
    for (int unsigned i = 0; i < 5; i++)
      run_txn(s_tab[i], f_tab[i], 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      r = 24'($urandom) >> $urandom_range(0, 22);
      if (i[0]) r = 24'd0 - r;
      run_txn(r, float_ref(r), 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_ready_stall;
    run_txn(24'h000003, 32'h40400000, 50, 2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_y_hold;
    run_txn(24'hFFFFFE, 32'hC0000000, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun;
    total++;
    if (ovr !== 1'b0) begin
      bad++; $display("FAIL overrun_initial got=%b exp=0", ovr);
    end
    run_txn(24'h000002, 32'h40000000, 0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (ovr !== 1'b1) begin
      bad++; $display("FAIL overrun_set got=%b exp=1", ovr);
    end
    run_txn(24'h000005, 32'h40A00000, 0, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (ovr !== 1'b1) begin
      bad++; $display("FAIL overrun_set_beats_clr got=%b exp=1", ovr);
    end
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    total++;
    if (ovr !== 1'b0) begin
      bad++; $display("FAIL overrun_clear got=%b exp=0", ovr);
    end
  endtask

  task automatic test_reset_abort;
    adc_data  = 24'h000001;
    adc_valid = 1'b1;
    tick;
    adc_valid = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    total++;
    if ({x_data, x_valid, y_ack, filt_data, filt_valid, busy, ovr} !== '0) begin
      bad++; $display("FAIL reset_in_norm got=%h/%b/%b/%h/%b/%b/%b exp=all0",
                      x_data, x_valid, y_ack, filt_data, filt_valid, busy, ovr);
    end
    tick;
    rst_n = 1'b1;
    tick;
    run_txn(24'h000001, 32'h3F800000, 0, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    xq.delete();
    yq.delete();
    run_txn(24'h000001, 32'h3F800000, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_convert;
    test_ready_stall;
    test_y_hold;
    test_overrun;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
